// File: rtl/tag_rx_pkg.sv
// Shared types and helpers for the tag RX symbol accumulator.
//   state_e : accumulator FSM encoding
//   rec_t   : one finished-symbol record as stored in the output FIFO; field
//             widths are the largest supported parameter values, so narrower
//             instances sign/zero-extend into it
//   sat_add : signed add clamped to a w-bit two's-complement range
package tag_rx_pkg;

   localparam int unsigned DROP_CNT_WIDTH  = 16;
   localparam int unsigned REC_ACC_WIDTH   = 40;
   localparam int unsigned REC_NSYMB_WIDTH = 16;
   localparam int unsigned REC_CNT_WIDTH   = 24;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_e;

   typedef struct packed {
      logic [REC_ACC_WIDTH-1:0]   isum;
      logic [REC_ACC_WIDTH-1:0]   qsum;
      logic [REC_NSYMB_WIDTH-1:0] symb;
      logic [REC_CNT_WIDTH-1:0]   cnt;
      logic                       tlast;
      logic                       sat;
   } rec_t;

   // a + b clamped to [-2^(w-1), 2^(w-1)-1]; sat flags a clamp (w <= 64)
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int unsigned        w,
                                                  output logic              sat);
      logic signed [64:0] sum;
      logic signed [64:0] hi;
      logic signed [64:0] lo;
      sum = 65'(a) + 65'(b);
      hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
      lo  = -(65'sd1 <<< (w - 1));
      sat = 1'b0;
      if (sum > hi) begin
         sat = 1'b1;
         return 64'(hi);
      end
      if (sum < lo) begin
         sat = 1'b1;
         return 64'(lo);
      end
      return 64'(sum);
   endfunction

endpackage

// File: rtl/tag_rx_rec_fifo.sv
// Two-entry register FIFO for symbol records.
//   push/push_data : write request; ignored when full unless popping this cycle
//   pop            : remove head; ignored when empty
//   pop_data       : head entry, straight from a register
//   full/empty     : registered occupancy flags
module tag_rx_rec_fifo #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem0;
   logic [WIDTH-1:0] mem1;
   logic             v0;
   logic             v1;
   logic             pop_ok_c;
   logic             push_ok_c;

   // a simultaneous pop frees a slot for the push
   assign pop_ok_c  = pop & v0;
   assign push_ok_c = push & (~v1 | pop_ok_c);

   // entry 0 is always the head; entry 1 shifts down on pop
   always_ff @(posedge clk) begin
      if (reset) begin
         mem0 <= '0;
         mem1 <= '0;
         v0   <= 1'b0;
         v1   <= 1'b0;
      end else if (pop_ok_c) begin
         if (v1) begin
            mem0 <= mem1;
            if (push_ok_c) mem1 <= push_data;
            else           v1   <= 1'b0;
         end else begin
            if (push_ok_c) mem0 <= push_data;
            else           v0   <= 1'b0;
         end
      end else if (push_ok_c) begin
         if (!v0) begin
            mem0 <= push_data;
            v0   <= 1'b1;
         end else begin
            mem1 <= push_data;
            v1   <= 1'b1;
         end
      end
   end

   assign pop_data = mem0;
   assign full     = v1;
   assign empty    = ~v0;

endmodule

// File: rtl/tag_rx_symb_acc.sv
// Per-symbol IQ integrator. Registers the RX stream once, sums I and Q over
// all qualifying samples (valid and not sync pattern) sharing a symbol index,
// and emits one record per symbol through a 2-deep valid/ready FIFO.
//   clk, reset                       : clock, synchronous active-high reset
//   in_valid, in_mux                 : sample valid, sync-pattern flag
//   irx_in, qrx_in, symb_in          : signed I/Q sample and symbol index
//   out_tvalid, out_tready           : record handshake
//   out_isum, out_qsum, out_symb,
//   out_cnt, out_tlast, out_sat      : head record fields
//   overflow, drop_cnt               : sticky drop flag and saturating drop count
module tag_rx_symb_acc
   import tag_rx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned NSYMB_WIDTH = 16,
   parameter int unsigned ACC_WIDTH   = 40,
   parameter int unsigned CNT_WIDTH   = 24,
   parameter int unsigned NSYMB       = 512
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic                      in_mux,
   input  logic [DATA_WIDTH-1:0]     irx_in,
   input  logic [DATA_WIDTH-1:0]     qrx_in,
   input  logic [NSYMB_WIDTH-1:0]    symb_in,
   output logic                      out_tvalid,
   input  logic                      out_tready,
   output logic [ACC_WIDTH-1:0]      out_isum,
   output logic [ACC_WIDTH-1:0]      out_qsum,
   output logic [NSYMB_WIDTH-1:0]    out_symb,
   output logic [CNT_WIDTH-1:0]      out_cnt,
   output logic                      out_tlast,
   output logic                      out_sat,
   output logic                      overflow,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

   // registered input sample
   logic                          v_q;
   logic                          m_q;
   logic signed [DATA_WIDTH-1:0]  i_q;
   logic signed [DATA_WIDTH-1:0]  q_q;
   logic [NSYMB_WIDTH-1:0]        s_q;

   state_e                        state, state_n;
   logic signed [ACC_WIDTH-1:0]   isum, isum_n;
   logic signed [ACC_WIDTH-1:0]   qsum, qsum_n;
   logic [NSYMB_WIDTH-1:0]        cur_symb, cur_symb_n;
   logic [CNT_WIDTH-1:0]          cnt, cnt_n;
   logic                          sat, sat_n;

   logic                          qual_c;
   logic                          push_c;
   logic                          pop_c;
   logic                          drop_c;
   logic                          full;
   logic                          empty;
   logic signed [63:0]            isum_add_c;
   logic signed [63:0]            qsum_add_c;
   logic                          isat_c;
   logic                          qsat_c;
   rec_t                          push_rec_c;
   rec_t                          head;

   // input register
   always_ff @(posedge clk) begin
      if (reset) begin
         v_q <= 1'b0;
         m_q <= 1'b0;
         i_q <= '0;
         q_q <= '0;
         s_q <= '0;
      end else begin
         v_q <= in_valid;
         m_q <= in_mux;
         i_q <= irx_in;
         q_q <= qrx_in;
         s_q <= symb_in;
      end
   end

   assign qual_c = v_q & ~m_q;

   // saturating sums of the running record and the registered sample
   always_comb begin
      isum_add_c = sat_add(64'(isum), 64'(i_q), ACC_WIDTH, isat_c);
      qsum_add_c = sat_add(64'(qsum), 64'(q_q), ACC_WIDTH, qsat_c);
   end

   // state and running-record registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         isum     <= '0;
         qsum     <= '0;
         cur_symb <= '0;
         cnt      <= '0;
         sat      <= 1'b0;
      end else begin
         state    <= state_n;
         isum     <= isum_n;
         qsum     <= qsum_n;
         cur_symb <= cur_symb_n;
         cnt      <= cnt_n;
         sat      <= sat_n;
      end
   end

   // next state, accumulation and record push
   always_comb begin
      state_n    = state;
      isum_n     = isum;
      qsum_n     = qsum;
      cur_symb_n = cur_symb;
      cnt_n      = cnt;
      sat_n      = sat;
      push_c     = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (qual_c) begin
               isum_n     = ACC_WIDTH'(i_q);
               qsum_n     = ACC_WIDTH'(q_q);
               cnt_n      = CNT_WIDTH'(1);
               cur_symb_n = s_q;
               sat_n      = 1'b0;
               state_n    = ST_ACC;
            end
         end
         ST_ACC: begin
            if (qual_c && (s_q == cur_symb)) begin
               isum_n = ACC_WIDTH'(isum_add_c);
               qsum_n = ACC_WIDTH'(qsum_add_c);
               cnt_n  = (cnt == '1) ? cnt : cnt + CNT_WIDTH'(1);
               sat_n  = sat | isat_c | qsat_c | (cnt == '1);
            end else if (qual_c) begin
               // symbol change: close this record and open the next in one cycle
               push_c     = 1'b1;
               isum_n     = ACC_WIDTH'(i_q);
               qsum_n     = ACC_WIDTH'(q_q);
               cnt_n      = CNT_WIDTH'(1);
               cur_symb_n = s_q;
               sat_n      = 1'b0;
            end else begin
               push_c  = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // record being closed, widened to the stored layout
   always_comb begin
      push_rec_c       = '0;
      push_rec_c.isum  = REC_ACC_WIDTH'(isum);
      push_rec_c.qsum  = REC_ACC_WIDTH'(qsum);
      push_rec_c.symb  = REC_NSYMB_WIDTH'(cur_symb);
      push_rec_c.cnt   = REC_CNT_WIDTH'(cnt);
      push_rec_c.tlast = (cur_symb == NSYMB_WIDTH'(NSYMB - 1));
      push_rec_c.sat   = sat;
   end

   assign pop_c  = ~empty & out_tready;
   assign drop_c = push_c & full & ~pop_c;

   tag_rx_rec_fifo #(
      .WIDTH($bits(rec_t))
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_c),
      .push_data (push_rec_c),
      .pop       (pop_c),
      .pop_data  (head),
      .full      (full),
      .empty     (empty)
   );

   // drop bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop_c) begin
         overflow <= 1'b1;
         if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
      end
   end

   assign out_tvalid = ~empty;
   assign out_isum   = head.isum[ACC_WIDTH-1:0];
   assign out_qsum   = head.qsum[ACC_WIDTH-1:0];
   assign out_symb   = head.symb[NSYMB_WIDTH-1:0];
   assign out_cnt    = head.cnt[CNT_WIDTH-1:0];
   assign out_tlast  = head.tlast;
   assign out_sat    = head.sat;

endmodule

// File: tb/tb_tag_rx_symb_acc.sv
// Self-checking bench for tag_rx_symb_acc: scoreboard of expected records,
// popped on every out_tvalid & out_tready handshake, plus per-test checks of
// timing, back-pressure, drops and reset. A second instance with a 20-bit
// accumulator shares the inputs for the saturation case.
module tb_tag_rx_symb_acc;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_mux;
   logic [15:0] irx_in, qrx_in, symb_in;
   logic        out_tvalid, out_tready;
   logic [39:0] out_isum, out_qsum;
   logic [15:0] out_symb;
   logic [23:0] out_cnt;
   logic        out_tlast, out_sat, overflow;
   logic [15:0] drop_cnt;

   logic        ds_tvalid;
   logic        ds_tready = 1'b1;
   logic [19:0] ds_isum, ds_qsum;
   logic [15:0] ds_symb;
   logic [23:0] ds_cnt;
   logic        ds_tlast, ds_sat, ds_overflow;
   logic [15:0] ds_drop_cnt;

   always #5 clk = ~clk;

   tag_rx_symb_acc dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_mux(in_mux),
      .irx_in(irx_in), .qrx_in(qrx_in), .symb_in(symb_in),
      .out_tvalid(out_tvalid), .out_tready(out_tready),
      .out_isum(out_isum), .out_qsum(out_qsum), .out_symb(out_symb),
      .out_cnt(out_cnt), .out_tlast(out_tlast), .out_sat(out_sat),
      .overflow(overflow), .drop_cnt(drop_cnt)
   );

   tag_rx_symb_acc #(.ACC_WIDTH(20)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_mux(in_mux),
      .irx_in(irx_in), .qrx_in(qrx_in), .symb_in(symb_in),
      .out_tvalid(ds_tvalid), .out_tready(ds_tready),
      .out_isum(ds_isum), .out_qsum(ds_qsum), .out_symb(ds_symb),
      .out_cnt(ds_cnt), .out_tlast(ds_tlast), .out_sat(ds_sat),
      .overflow(ds_overflow), .drop_cnt(ds_drop_cnt)
   );

   typedef struct {
      longint isum;
      longint qsum;
      int     symb;
      int     cnt;
      bit     tlast;
      bit     sat;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic exp_t mk(longint i, longint q, int s, int c, bit t, bit st);
      exp_t e;
      e.isum = i; e.qsum = q; e.symb = s; e.cnt = c; e.tlast = t; e.sat = st;
      return e;
   endfunction

   // drive one sample, score any handshake at the falling edge, end at posedge+1
   task automatic step(input bit v, input bit m, input int i, input int q, input int s);
      exp_t e;
      in_valid = v;
      in_mux   = m;
      irx_in   = 16'(i);
      qrx_in   = 16'(q);
      symb_in  = 16'(s);
      @(negedge clk);
      if (!reset && out_tvalid && out_tready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL record: unexpected record symb=%0d isum=%0d cnt=%0d",
                     out_symb, $signed(out_isum), out_cnt);
         end else begin
            e = exp_q.pop_front();
            if (longint'($signed(out_isum)) !== e.isum || longint'($signed(out_qsum)) !== e.qsum ||
                int'(out_symb) !== e.symb || int'(out_cnt) !== e.cnt ||
                out_tlast !== e.tlast || out_sat !== e.sat) begin
               errors++;
               $display("FAIL record: got isum=%0d qsum=%0d symb=%0d cnt=%0d tlast=%0b sat=%0b, want isum=%0d qsum=%0d symb=%0d cnt=%0d tlast=%0b sat=%0b",
                        $signed(out_isum), $signed(out_qsum), out_symb, out_cnt, out_tlast, out_sat,
                        e.isum, e.qsum, e.symb, e.cnt, e.tlast, e.sat);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      out_tready = 1'b1;
      idle(3);
      reset = 1'b0;
      checks++;
      if (out_tvalid !== 1'b0 || out_isum !== '0 || out_qsum !== '0 || out_symb !== '0 ||
          out_cnt !== '0 || out_tlast !== 1'b0 || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: tvalid=%0b isum=%0d qsum=%0d symb=%0d cnt=%0d tlast=%0b sat=%0b, want all 0",
                  out_tvalid, out_isum, out_qsum, out_symb, out_cnt, out_tlast, out_sat);
      end
      checks++;
      if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_drop: overflow=%0b drop_cnt=%0d, want 0 0", overflow, drop_cnt);
      end
   endtask

   task automatic test_basic;
      exp_q.push_back(mk(800, -400, 3, 8, 0, 0));
      exp_q.push_back(mk(100, -50, 4, 1, 0, 0));
      for (int k = 0; k < 8; k++) step(1, 0, 100, -50, 3);
      step(1, 0, 100, -50, 4);
      checks++;
      if (out_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL basic_latency1: tvalid=%0b one cycle after boundary, want 0", out_tvalid);
      end
      step(0, 0, 0, 0, 0);
      checks++;
      if (out_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL basic_latency2: tvalid=%0b two cycles after boundary, want 1", out_tvalid);
      end
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) idle(1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_drain: %0d records missing, want 0", exp_q.size());
      end
   endtask

   task automatic test_sync;
      exp_q.push_back(mk(4, 0, 0, 4, 0, 0));
      for (int k = 0; k < 10; k++) step(1, 1, 16384, 0, 0);
      for (int k = 0; k < 4; k++) step(1, 0, 1, 0, 0);
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) idle(1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sync_drain: %0d records missing, want 0", exp_q.size());
      end
      idle(3);
   endtask

   task automatic test_backpressure;
      logic [39:0] held;
      out_tready = 1'b0;
      exp_q.push_back(mk(20, -20, 10, 2, 0, 0));
      exp_q.push_back(mk(22, -22, 11, 2, 0, 0));
      for (int s = 10; s <= 12; s++) begin
         step(1, 0, s, -s, s);
         step(1, 0, s, -s, s);
      end
      idle(4);
      held = out_isum;
      checks++;
      if (out_tvalid !== 1'b1 || out_symb !== 16'd10) begin
         errors++;
         $display("FAIL bp_head: tvalid=%0b symb=%0d, want 1 10", out_tvalid, out_symb);
      end
      checks++;
      if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin
         errors++;
         $display("FAIL bp_drop: overflow=%0b drop_cnt=%0d, want 1 1", overflow, drop_cnt);
      end
      idle(3);
      checks++;
      if (out_isum !== held || out_symb !== 16'd10 || out_isum !== 40'd20) begin
         errors++;
         $display("FAIL bp_stable: isum=%0d symb=%0d, want 20 10", out_isum, out_symb);
      end
      out_tready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) idle(1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_drain: %0d records missing, want 0", exp_q.size());
      end
      idle(2);
   endtask

   task automatic test_back_to_back;
      for (int s = 30; s < 36; s++) exp_q.push_back(mk(s, 1, s, 1, 0, 0));
      for (int s = 30; s < 36; s++) step(1, 0, s, 1, s);
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) idle(1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: %0d records missing, want 0", exp_q.size());
      end
      checks++;
      if (drop_cnt !== 16'd1) begin
         errors++;
         $display("FAIL b2b_nodrop: drop_cnt=%0d, want 1", drop_cnt);
      end
   endtask

   task automatic test_saturation;
      bit          found = 1'b0;
      logic [19:0] s_isum = '0;
      logic [23:0] s_cnt = '0;
      logic        s_sat = 1'b0;
      exp_q.push_back(mk(2097088, 0, 20, 64, 0, 0));
      for (int k = 0; k < 64; k++) step(1, 0, 32767, 0, 20);
      for (int c = 0; c < 10; c++) begin
         idle(1);
         if (!found && ds_tvalid === 1'b1 && ds_symb === 16'd20) begin
            found  = 1'b1;
            s_isum = ds_isum;
            s_cnt  = ds_cnt;
            s_sat  = ds_sat;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL sat_present: no record from 20-bit instance within 10 cycles");
      end else begin
         checks++;
         if (s_isum !== 20'd524287 || s_sat !== 1'b1 || s_cnt !== 24'd64) begin
            errors++;
            $display("FAIL sat_value: isum=%0d sat=%0b cnt=%0d, want 524287 1 64", s_isum, s_sat, s_cnt);
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sat_drain: %0d records missing, want 0", exp_q.size());
      end
   endtask

   task automatic test_frame_end;
      exp_q.push_back(mk(15, 21, 510, 3, 0, 0));
      exp_q.push_back(mk(10, 14, 511, 2, 1, 0));
      for (int k = 0; k < 3; k++) step(1, 0, 5, 7, 510);
      for (int k = 0; k < 2; k++) step(1, 0, 5, 7, 511);
      step(0, 0, 0, 0, 0);
      checks++;
      if (out_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL frame_latency1: tvalid=%0b one cycle after valid fell, want 0", out_tvalid);
      end
      step(0, 0, 0, 0, 0);
      checks++;
      if (out_tvalid !== 1'b1 || out_tlast !== 1'b1 || out_symb !== 16'd511) begin
         errors++;
         $display("FAIL frame_latency2: tvalid=%0b tlast=%0b symb=%0d, want 1 1 511",
                  out_tvalid, out_tlast, out_symb);
      end
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) idle(1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL frame_drain: %0d records missing, want 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid;
      out_tready = 1'b0;
      for (int k = 0; k < 5; k++) step(1, 0, 9, 9, 5);
      for (int k = 0; k < 5; k++) step(1, 0, 50, 50, 6);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      checks++;
      if (out_tvalid !== 1'b0 || out_isum !== '0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL midreset_clear: tvalid=%0b isum=%0d overflow=%0b drop_cnt=%0d, want 0 0 0 0",
                  out_tvalid, out_isum, overflow, drop_cnt);
      end
      out_tready = 1'b1;
      exp_q.push_back(mk(6, 0, 7, 3, 0, 0));
      for (int k = 0; k < 3; k++) step(1, 0, 2, 0, 7);
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) idle(1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL midreset_drain: %0d records missing, want 0", exp_q.size());
      end
      idle(4);
   endtask

   initial begin
      reset      = 1'b1;
      out_tready = 1'b1;
      in_valid   = 1'b0;
      in_mux     = 1'b0;
      irx_in     = '0;
      qrx_in     = '0;
      symb_in    = '0;
      @(posedge clk);
      #1;
      test_reset;
      test_basic;
      test_sync;
      test_backpressure;
      test_back_to_back;
      test_saturation;
      test_frame_end;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
